// File: rtl/instr_fetch_seq_if.sv
// Sequencer-side bundle: switch/button controls in, instruction word and status out.
interface instr_fetch_seq_if #(
  parameter int AW = 3,
  parameter int IW = 12
);
  logic          load_en;
  logic          step_pulse;
  logic          run;
  logic [IW-1:0] sw_instr;
  logic [IW-1:0] instr;
  logic          exec_pulse;
  logic [AW-1:0] pc;
  logic [AW:0]   prog_len;
  logic          load_full;
  logic          halted;

  modport master (
    output load_en, step_pulse, run, sw_instr,
    input  instr, exec_pulse, pc, prog_len, load_full, halted
  );

  modport slave (
    input  load_en, step_pulse, run, sw_instr,
    output instr, exec_pulse, pc, prog_len, load_full, halted
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Program sequencer: switch-loaded instruction memory, stepped or free-run, one-cycle exec_pulse per issue.
// LOOP_EN: wrap to pc 0 after the last word instead of halting.
module instr_fetch_seq #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int IW      = 12,
  parameter int RUN_DIV = 4
) (
  input logic              clk,
  input logic              reset,
  instr_fetch_seq_if.slave bus
);

  localparam int CW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  typedef enum logic [1:0] {S_LOAD, S_READY, S_ISSUE, S_HALT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] pc, pc_nxt, load_ptr;
  logic [AW:0]   prog_len;
  logic [IW-1:0] instr;
  logic [CW-1:0] run_cnt, run_cnt_nxt;
  logic          enter_load, fetch, wr_en, load_full;
  logic          is_jmp, jmp_ok, last_word, run_tick;
  logic [AW-1:0] jmp_tgt;

  // JMP is consumed by the sequencer and never reaches the datapath.
  assign is_jmp    = (instr[11:9] == 3'b111);
  assign jmp_tgt   = AW'(instr[2:0]);
  assign jmp_ok    = ((AW+1)'(instr[2:0]) < prog_len);
  assign last_word = ({1'b0, pc} == (prog_len - (AW+1)'(1)));
  assign run_tick  = bus.run && (run_cnt == CW'(RUN_DIV - 1));
  assign load_full = (prog_len == (AW+1)'(DEPTH));
  assign wr_en     = (state == S_LOAD) && bus.load_en && bus.step_pulse && !load_full;

  always_ff @(posedge clk) begin
    if (reset) state <= S_HALT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    run_cnt_nxt = '0;
    enter_load  = 1'b0;
    fetch       = 1'b0;
    case (state)
      S_LOAD: begin
        if (!bus.load_en) begin
          if (prog_len == '0) begin
            state_nxt = S_HALT;
          end else begin
            state_nxt = S_READY;
            pc_nxt    = '0;
            fetch     = 1'b1;
          end
        end
      end
      S_READY: begin
        if (bus.load_en) begin
          state_nxt  = S_LOAD;
          enter_load = 1'b1;
        end else if (bus.step_pulse || run_tick) begin
          state_nxt = S_ISSUE;
        end else if (bus.run) begin
          run_cnt_nxt = run_cnt + CW'(1);
        end
      end
      S_ISSUE: begin
        if (bus.load_en) begin
          state_nxt  = S_LOAD;
          enter_load = 1'b1;
        end else if (is_jmp) begin
          if (jmp_ok) begin
            state_nxt = S_READY;
            pc_nxt    = jmp_tgt;
            fetch     = 1'b1;
          end else begin
            state_nxt = S_HALT;
          end
        end else if (last_word) begin
`ifdef LOOP_EN
          state_nxt = S_READY;
          pc_nxt    = '0;
          fetch     = 1'b1;
`else
          state_nxt = S_HALT;
`endif
        end else begin
          state_nxt = S_READY;
          pc_nxt    = pc + AW'(1);
          fetch     = 1'b1;
        end
      end
      S_HALT: begin
        if (bus.load_en) begin
          state_nxt  = S_LOAD;
          enter_load = 1'b1;
        end else if (bus.step_pulse && (prog_len != '0)) begin
          state_nxt = S_READY;
          pc_nxt    = '0;
          fetch     = 1'b1;
        end
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      load_ptr <= '0;
      prog_len <= '0;
      instr    <= '0;
      run_cnt  <= '0;
    end else begin
      pc      <= pc_nxt;
      run_cnt <= run_cnt_nxt;
      if (enter_load) begin
        prog_len <= '0;
        load_ptr <= '0;
        instr    <= '0;
      end else if (wr_en) begin
        load_ptr <= load_ptr + AW'(1);
        prog_len <= prog_len + (AW+1)'(1);
      end
      if (fetch) instr <= mem[pc_nxt];
    end
  end

  // Memory is deliberately not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[load_ptr] <= bus.sw_instr;
  end

  assign bus.instr      = instr;
  assign bus.pc         = pc;
  assign bus.prog_len   = prog_len;
  assign bus.load_full  = load_full;
  assign bus.halted     = (state == S_HALT);
  assign bus.exec_pulse = (state == S_ISSUE) && !is_jmp;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboarded bench: a program-level model queues expected exec events; a monitor checks each pulse.
module tb_instr_fetch_seq;
  localparam int DEPTH = 8, AW = 3, IW = 12, RUN_DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  instr_fetch_seq_if #(.AW(AW), .IW(IW)) bus();

  instr_fetch_seq #(.DEPTH(DEPTH), .AW(AW), .IW(IW), .RUN_DIV(RUN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    int            gap;
  } exp_t;

  exp_t          expq[$];
  exp_t          e;
  int            checks = 0, errors = 0;
  int            cyc = 0, last_pulse = 0;
  bit            prev_exec = 0;
  logic [IW-1:0] mem_m [DEPTH];
  logic [IW-1:0] prog [16];
  int            plen_m = 0, pc_m = 0;
  bit            halt_m = 1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      prev_exec = 0;
    end else begin
      if (bus.exec_pulse) begin
        checks++;
        if (prev_exec) begin
          errors++;
          $display("FAIL back_to_back_pulse: exec_pulse high 2 cycles running at pc=%0d, required single-cycle", bus.pc);
        end
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: pc=%0d instr=%h, required no pulse", bus.pc, bus.instr);
        end else begin
          e = expq.pop_front();
          if (bus.instr !== e.instr || bus.pc !== e.pc ||
              (e.gap != 0 && (cyc - last_pulse) != e.gap)) begin
            errors++;
            $display("FAIL pulse_content: pc=%0d instr=%h gap=%0d, required pc=%0d instr=%h gap=%0d",
                     bus.pc, bus.instr, cyc - last_pulse, e.pc, e.instr, e.gap);
          end
        end
        last_pulse = cyc;
      end
      prev_exec = bus.exec_pulse;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Program-level semantics of one issue at the current pc.
  task automatic model_issue(input int gap, output bit pulsed);
    logic [IW-1:0] w;
    w = mem_m[pc_m];
    pulsed = 0;
    if (w[11:9] == 3'b111) begin
      if (int'(w[2:0]) < plen_m) pc_m = int'(w[2:0]);
      else halt_m = 1;
    end else begin
      expq.push_back('{AW'(pc_m), w, gap});
      pulsed = 1;
      if (pc_m == plen_m - 1) begin
`ifdef LOOP_EN
        pc_m = 0;
`else
        halt_m = 1;
`endif
      end else begin
        pc_m++;
      end
    end
  endtask

  task automatic check_reset_vals();
    check("rst_halted", bus.halted, 1);
    check("rst_pc", bus.pc, 0);
    check("rst_prog_len", bus.prog_len, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_exec", bus.exec_pulse, 0);
    check("rst_load_full", bus.load_full, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    halt_m = 1; plen_m = 0; pc_m = 0;
    expq.delete();
    check_reset_vals();
  endtask

  task automatic do_load(input int n);
    bus.load_en = 1'b1;
    tick(1);
    check("load_entry_prog_len", bus.prog_len, 0);
    check("load_entry_instr", bus.instr, 0);
    for (int i = 0; i < n; i++) begin
      bus.sw_instr = prog[i];
      bus.step_pulse = 1'b1;
      tick(1);
      bus.step_pulse = 1'b0;
      tick(1);
      if (i < DEPTH) mem_m[i] = prog[i];
    end
    plen_m = (n < DEPTH) ? n : DEPTH;
    check("load_full", bus.load_full, (plen_m == DEPTH) ? 1 : 0);
    bus.load_en = 1'b0;
    tick(2);
    check("load_prog_len", bus.prog_len, plen_m);
    if (plen_m == 0) begin
      halt_m = 1;
    end else begin
      halt_m = 0;
      pc_m = 0;
      check("load_instr0", bus.instr, mem_m[0]);
      check("load_pc0", bus.pc, 0);
    end
    check("load_halted", bus.halted, halt_m);
  endtask

  task automatic do_step();
    bit p;
    if (halt_m) begin
      if (plen_m > 0) begin halt_m = 0; pc_m = 0; end
    end else begin
      model_issue(0, p);
    end
    bus.step_pulse = 1'b1;
    tick(1);
    bus.step_pulse = 1'b0;
    tick(3);
  endtask

  task automatic do_run(input int n);
    int since;
    bit first, p;
    since = 0; first = 1;
    for (int k = 0; k < n; k++) begin
      if (halt_m) break;
      since += RUN_DIV + 1;
      model_issue(first ? 0 : since, p);
      if (p) begin first = 0; since = 0; end
    end
    bus.run = 1'b1;
    tick(n * (RUN_DIV + 1));
    bus.run = 1'b0;
    tick(2);
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_halted"}, bus.halted, halt_m);
    check({tag, "_pc"}, bus.pc, pc_m);
    if (!halt_m) check({tag, "_instr"}, bus.instr, mem_m[pc_m]);
  endtask

  initial begin
    bit p;
    int n;
    logic [IW-1:0] w;
    bus.load_en = 0; bus.step_pulse = 0; bus.run = 0; bus.sw_instr = '0;

    do_reset();

    // Three-word program, stepped past the end, then restarted
    prog[0] = 12'h0C1; prog[1] = 12'h6D2; prog[2] = 12'h4E3;
    do_load(3);
    check("t1_exec_idle", bus.exec_pulse, 0);
    repeat (3) do_step();
    check_pos("t2_end");
    do_step();
    check_pos("t2_restart");

    // Overfill: the ninth word must not land anywhere
    for (int i = 0; i < 9; i++) prog[i] = 12'h100 + IW'(i);
    do_load(9);

    // Free run with a JMP back to 0
    prog[0] = 12'h0C1; prog[1] = 12'hE00; prog[2] = 12'h6D2;
    do_load(3);
    do_run(6);
    check_pos("t4_run");

    // JMP beyond program end halts without a pulse
    prog[1] = 12'hE05;
    do_load(3);
    do_step();
    model_issue(0, p);
    bus.step_pulse = 1'b1;
    tick(1);
    bus.step_pulse = 1'b0;
    check("t5_jmp_no_exec", bus.exec_pulse, 0);
    tick(1);
    check("t5_halted", bus.halted, 1);
    check("t5_pc", bus.pc, 1);

    // load_en during ISSUE, then reset during LOAD with a pending write
    prog[1] = 12'h6D2;
    do_load(3);
    model_issue(0, p);
    bus.step_pulse = 1'b1;
    tick(1);
    bus.step_pulse = 1'b0;
    bus.load_en = 1'b1;
    check("t6_issue_exec", bus.exec_pulse, 1);
    tick(1);
    check("t6_load_exec", bus.exec_pulse, 0);
    check("t6_load_prog_len", bus.prog_len, 0);
    check("t6_load_instr", bus.instr, 0);
    bus.sw_instr = 12'h123;
    bus.step_pulse = 1'b1;
    tick(1);
    bus.step_pulse = 1'b0;
    tick(1);
    check("t6_load_one", bus.prog_len, 1);
    bus.sw_instr = 12'h456;
    bus.step_pulse = 1'b1;
    reset = 1'b1;
    tick(1);
    bus.step_pulse = 1'b0;
    bus.load_en = 1'b0;
    tick(1);
    reset = 1'b0;
    halt_m = 1; plen_m = 0; pc_m = 0;
    check_reset_vals();

    // Randomized programs and step/run mixes
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, 9);
      for (int i = 0; i < n; i++) begin
        w = IW'($urandom);
        if ($urandom_range(0, 3) == 0) w[11:9] = 3'b111;
        else if (w[11:9] == 3'b111) w[11] = 1'b0;
        prog[i] = w;
      end
      do_load(n);
      for (int op = 0; op < 8; op++) begin
        if ($urandom_range(0, 2) == 0) do_run($urandom_range(1, 5));
        else do_step();
      end
      check_pos("rnd_end");
    end

    tick(5);
    check("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
Program sequencer that sits directly upstream of the 12-bit datapath (controller + regfile + alu4 + dmem).
- Holds a small instruction memory, loaded word-by-word from the board switches.
- Steps or free-runs through the program and presents a stable instr word with a one-cycle exec_pulse that clocks the datapath.
- Replaces driving the datapath straight from the switches with a debounced button.

Parameters:
DEPTH, 8, instruction memory entries (power of two)
AW, 3, PC / load-pointer width, log2(DEPTH)
IW, 12, instruction width
RUN_DIV, 4, clk cycles between issues in run mode (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load_en  in  1  program-load mode switch (level)
step_pulse  in  1  debounced single-cycle button pulse
run  in  1  free-run enable (level)
sw_instr  in  IW  instruction word from switches
instr  out  IW  registered instruction to datapath
exec_pulse  out  1  one-cycle strobe: datapath executes instr
pc  out  AW  address of the word on instr
prog_len  out  AW+1  number of loaded words, 0..DEPTH
load_full  out  1  prog_len==DEPTH
halted  out  1  sequencer in HALT

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock port is clk; reset port is reset.
- Reset values:
  - state=HALT, pc=0, prog_len=0, instr=0, exec_pulse=0, halted=1, load_full=0, run counter=0.
  - Memory contents are not cleared.
- States: LOAD, READY, ISSUE, HALT.
- load_en priority: load_en=1 in READY or HALT moves to LOAD next cycle. In ISSUE, the pulse completes first, then the FSM goes to LOAD.
- Entering LOAD clears prog_len and load_ptr, holds instr=0, and keeps exec_pulse=0.
- LOAD:
  - On step_pulse with prog_len<DEPTH: mem[load_ptr]<=sw_instr, load_ptr++, prog_len++.
  - When prog_len==DEPTH, step_pulse is ignored and load_full=1.
- Leaving LOAD (load_en falls):
  - If prog_len==0, go to HALT.
  - Otherwise pc<=0 and go to READY. instr<=mem[0] is valid on the first READY cycle.
- READY:
  - instr holds mem[pc].
  - Issue trigger: step_pulse, or run=1 with the run counter reaching RUN_DIV-1.
  - The run counter counts only in READY with run=1. It clears on issue and when run=0.
  - On trigger, go to ISSUE.
- ISSUE (exactly one cycle):
  - exec_pulse=1, unless instr[11:9]==3'b111 (JMP, sequencer-only, never executed by the datapath).
  - instr and pc stay stable during ISSUE.
- Next pc after ISSUE:
  - For JMP: target=instr[2:0]. If target<prog_len, pc<=target and go to READY; otherwise go to HALT.
  - Otherwise, if pc==prog_len-1, go to HALT (see LOOP_EN); else pc<=pc+1 and go to READY.
  - instr updates to mem[new pc] on entering READY.
- HALT:
  - halted=1, exec_pulse=0, instr holds its last value.
  - On step_pulse with load_en=0 and prog_len>0: pc<=0, instr<=mem[0], go to READY (restart).
  - run=1 alone does not restart.
- Simultaneous events:
  - step_pulse and a run tick in the same cycle cause one issue only.
  - load_en outranks step_pulse.
  - reset outranks everything, including a mid-LOAD write (the write is dropped).
- exec_pulse is never high on two consecutive cycles. Minimum spacing between pulses is 2 cycles.

Optional Feature:
LOOP_EN:
- Defined: after ISSUE of the last word (pc==prog_len-1, non-JMP), pc wraps to 0 and the FSM goes to READY instead of HALT. The program repeats until load_en or reset.
- Undefined: the FSM halts at the end of the program as specified above.

Test Plan:
1. Reset, then load 3 words (12'h0C1, 12'h6D2, 12'h4E3) via step_pulse with load_en=1, then drop load_en -> prog_len=3, pc=0, instr=12'h0C1, halted=0, exec_pulse=0.
2. From 1, apply 3 step_pulses -> 3 single-cycle exec_pulses with instr 0C1, 6D2, 4E3 in order; after the third, halted=1 and pc=2; a further step_pulse restarts at pc=0.
3. Load 9 words -> after 8, load_full=1 and prog_len=8; the 9th write is ignored and mem[0] is unchanged.
4. Program {12'h0C1, 12'hE00 (JMP 0), 12'h6D2}, run=1, RUN_DIV=4 -> pulses only for 0C1, pc sequence 0,1,0,1…; no exec_pulse while JMP is on instr; issue spacing is 5 cycles (4 READY + 1 ISSUE).
5. JMP to target 5 with prog_len=3 -> no exec_pulse, halted=1 on the next cycle.
6. Assert load_en during ISSUE, and reset during LOAD -> the exec_pulse still completes its one cycle, the FSM enters LOAD with prog_len=0; reset returns all outputs to reset values. With LOOP_EN, test 2 wraps to pc=0 instead of halting.
